// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - shared pipeline constants for the writeback stage
//
// Holds the writeback result-select encoding shared with the decode stage,
// default data/register widths and the halt FSM state type.
package writeback_stage_pkg;

  localparam int WB_DW    = 16;
  localparam int WB_RW    = 4;
  localparam int WB_CNT_W = 16;

  localparam logic [1:0] WB_SEL_ALU   = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD  = 2'b01;
  localparam logic [1:0] WB_SEL_PC2   = 2'b10;
  localparam logic [1:0] WB_SEL_MERGE = 2'b11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_result_mux.sv
// rtl/wb_result_mux.sv - writeback result select and LLB/LHB byte merge
//
// Ports:
//   wb_sel  in  2   result source (ALU, load, PC+2, byte merge)
//   alu     in  W   ALU result
//   ldata   in  W   load data
//   pc2     in  W   link value
//   imm8    in  8   LLB/LHB immediate
//   hi      in  1   1 = replace upper byte (LHB), 0 = lower byte (LLB)
//   old     in  W   current destination value for the merge
//   result  out W   selected writeback value
module wb_result_mux
  import writeback_stage_pkg::*;
#(
  parameter int W = WB_DW
) (
  input  logic [1:0]   wb_sel,
  input  logic [W-1:0] alu,
  input  logic [W-1:0] ldata,
  input  logic [W-1:0] pc2,
  input  logic [7:0]   imm8,
  input  logic         hi,
  input  logic [W-1:0] old,
  output logic [W-1:0] result
);

  logic [W-1:0] merged;

  always_comb begin
    merged = hi ? {imm8, old[W-9:0]} : {old[W-1:8], imm8};
  end

  always_comb begin
    result = alu;
    case (wb_sel)
      WB_SEL_ALU:   result = alu;
      WB_SEL_LOAD:  result = ldata;
      WB_SEL_PC2:   result = pc2;
      WB_SEL_MERGE: result = merged;
      default:      result = alu;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, regfile write driver, halt FSM and retire counter
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   mem_valid/we/dst/wb_sel      retiring instruction control from MEM
//   mem_alu/ldata/pc2/imm8/hi/old result sources and byte-merge operands
//   mem_halt                     instruction is HLT
//   wb_stall, wb_flush           hold the entry / replace it with a bubble
//   WriteReg, DstReg, DstData    register file write port
//   wb_halted                    core halted until reset
//   retired                      retired valid instruction count (wrapping)
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DW    = WB_DW,
  parameter int RW    = WB_RW,
  parameter int CNT_W = WB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_we,
  input  logic [RW-1:0]    mem_dst,
  input  logic [1:0]       mem_wb_sel,
  input  logic [DW-1:0]    mem_alu,
  input  logic [DW-1:0]    mem_ldata,
  input  logic [DW-1:0]    mem_pc2,
  input  logic [7:0]       mem_imm8,
  input  logic             mem_hi,
  input  logic [DW-1:0]    mem_old,
  input  logic             mem_halt,
  input  logic             wb_stall,
  input  logic             wb_flush,
  output logic             WriteReg,
  output logic [RW-1:0]    DstReg,
  output logic [DW-1:0]    DstData,
  output logic             wb_halted,
  output logic [CNT_W-1:0] retired
);

  logic [DW-1:0] sel_result;

  wb_result_mux #(.W(DW)) u_result_mux (
    .wb_sel (mem_wb_sel),
    .alu    (mem_alu),
    .ldata  (mem_ldata),
    .pc2    (mem_pc2),
    .imm8   (mem_imm8),
    .hi     (mem_hi),
    .old    (mem_old),
    .result (sel_result)
  );

  logic             valid_q, valid_d;
  logic             fresh_q, fresh_d;
  logic             we_q, we_d;
  logic             halt_q, halt_d;
  logic [RW-1:0]    dst_q, dst_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  wb_state_e        state_q, state_d;

  // An entry acts exactly once: in the first cycle it is presented, and only
  // while the core is still running.
  logic present;

  always_comb begin
    present   = valid_q & fresh_q & (state_q == ST_RUN);

    valid_d   = valid_q;
    fresh_d   = fresh_q;
    we_d      = we_q;
    halt_d    = halt_q;
    dst_d     = dst_q;
    data_d    = data_q;
    retired_d = present ? retired_q + CNT_W'(1) : retired_q;
    state_d   = (present && halt_q) ? ST_HALTED : state_q;

    if (wb_flush) begin
      // Fields are kept so DstReg/DstData still show the last entry.
      valid_d = 1'b0;
      fresh_d = 1'b0;
    end else if (!wb_stall) begin
      valid_d = mem_valid;
      fresh_d = mem_valid;
      we_d    = mem_we;
      halt_d  = mem_halt;
      dst_d   = mem_dst;
      data_d  = sel_result;
    end else begin
      fresh_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      fresh_q   <= 1'b0;
      we_q      <= 1'b0;
      halt_q    <= 1'b0;
      dst_q     <= '0;
      data_q    <= '0;
      retired_q <= '0;
      state_q   <= ST_RUN;
    end else begin
      valid_q   <= valid_d;
      fresh_q   <= fresh_d;
      we_q      <= we_d;
      halt_q    <= halt_d;
      dst_q     <= dst_d;
      data_q    <= data_d;
      retired_q <= retired_d;
      state_q   <= state_d;
    end
  end

  // HLT itself never writes, even if its we bit is set.
  assign WriteReg  = present & we_q & ~halt_q;
  assign DstReg    = dst_q;
  assign DstData   = data_q;
  assign wb_halted = (state_q == ST_HALTED);
  assign retired   = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, mem_we = 1'b0, mem_hi = 1'b0, mem_halt = 1'b0;
  logic [3:0]  mem_dst = '0;
  logic [1:0]  mem_wb_sel = '0;
  logic [15:0] mem_alu = '0, mem_ldata = '0, mem_pc2 = '0, mem_old = '0;
  logic [7:0]  mem_imm8 = '0;
  logic        wb_stall = 1'b0, wb_flush = 1'b0;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic        wb_halted;
  logic [15:0] retired;

  writeback_stage dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_dst(mem_dst),
    .mem_wb_sel(mem_wb_sel), .mem_alu(mem_alu), .mem_ldata(mem_ldata),
    .mem_pc2(mem_pc2), .mem_imm8(mem_imm8), .mem_hi(mem_hi),
    .mem_old(mem_old), .mem_halt(mem_halt),
    .wb_stall(wb_stall), .wb_flush(wb_flush),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .wb_halted(wb_halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dst;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  // Reference model state: an accepted instruction is "pending" until the
  // edge that ends its presentation cycle.
  int unsigned m_retired = 0;
  bit          m_halted  = 1'b0;
  bit          m_pending = 1'b0;
  bit          m_pending_halt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [15:0] ref_result(input logic [1:0] sel, input logic [15:0] alu,
      input logic [15:0] ld, input logic [15:0] pc2, input logic [7:0] imm8,
      input logic hi, input logic [15:0] old);
    case (sel)
      2'd0:    return alu;
      2'd1:    return ld;
      2'd2:    return pc2;
      default: return hi ? {imm8, old[7:0]} : {old[15:8], imm8};
    endcase
  endfunction

  // Advance one clock edge and update the model with what the edge did.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    if (m_pending && !m_halted) begin
      m_retired = (m_retired + 1) % 65536;
      if (m_pending_halt) m_halted = 1'b1;
    end
    m_pending = 1'b0;
    if (mem_valid && !wb_stall && !wb_flush) begin
      m_pending      = 1'b1;
      m_pending_halt = mem_halt;
      if (!m_halted && mem_we && !mem_halt) begin
        w.dst  = mem_dst;
        w.data = ref_result(mem_wb_sel, mem_alu, mem_ldata, mem_pc2, mem_imm8, mem_hi, mem_old);
        exp_q.push_back(w);
      end
    end
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0; mem_we = 1'b0; mem_halt = 1'b0;
    wb_stall = 1'b0; wb_flush = 1'b0;
  endtask

  task automatic instr(input logic we, input logic [3:0] dst, input logic [1:0] sel,
                       input logic [15:0] val, input logic halt);
    mem_valid = 1'b1; mem_we = we; mem_dst = dst; mem_wb_sel = sel; mem_halt = halt;
    mem_alu = val; mem_ldata = val; mem_pc2 = val;
    wb_stall = 1'b0; wb_flush = 1'b0;
  endtask

  task automatic rand_inputs();
    mem_valid  = ($urandom % 5) != 0;
    mem_we     = ($urandom % 4) != 0;
    mem_dst    = 4'($urandom);
    mem_wb_sel = 2'($urandom);
    mem_alu    = 16'($urandom);
    mem_ldata  = 16'($urandom);
    mem_pc2    = 16'($urandom);
    mem_imm8   = 8'($urandom);
    mem_hi     = 1'($urandom);
    mem_old    = 16'($urandom);
    mem_halt   = ($urandom % 60) == 0;
    wb_stall   = ($urandom % 5) == 0;
    wb_flush   = ($urandom % 8) == 0;
  endtask

  // Asynchronous reset in the middle of a cycle; any pending write is lost.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    m_retired = 0; m_halted = 1'b0; m_pending = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_writereg", {31'b0, WriteReg}, 32'd0);
    chk("reset_retired", {16'b0, retired}, 32'd0);
    chk("reset_halted", {31'b0, wb_halted}, 32'd0);
    chk("reset_dstreg", {28'b0, DstReg}, 32'd0);
    chk("reset_dstdata", {16'b0, DstData}, 32'd0);
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every presented write must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t w;
    if (WriteReg) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", {31'b0, WriteReg}, 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("write_dst", {28'b0, DstReg}, {28'b0, w.dst});
        chk("write_data", {16'b0, DstData}, {16'b0, w.data});
      end
    end
    chk("retired", {16'b0, retired}, m_retired);
    chk("halted", {31'b0, wb_halted}, {31'b0, m_halted});
  end

  int halt_cycles;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // ALU write to r3
    instr(1'b1, 4'd3, 2'b00, 16'h1234, 1'b0); tick();
    idle(); tick();

    // LLB then LHB byte merge
    instr(1'b1, 4'd4, 2'b11, 16'h0, 1'b0);
    mem_old = 16'hABCD; mem_imm8 = 8'h5A; mem_hi = 1'b0; tick();
    mem_hi = 1'b1; tick();
    idle(); tick();

    // load captured, then held by three stall cycles
    instr(1'b1, 4'd7, 2'b01, 16'hBEEF, 1'b0); tick();
    wb_stall = 1'b1;
    mem_ldata = 16'h1111;
    repeat (3) tick();
    chk("stall_hold_data", {16'b0, DstData}, 32'h0000BEEF);
    idle(); tick();

    // flush and stall together on a valid entry
    instr(1'b1, 4'd5, 2'b00, 16'h0A0A, 1'b0); tick();
    instr(1'b1, 4'd6, 2'b00, 16'h0B0B, 1'b0);
    wb_flush = 1'b1; wb_stall = 1'b1; tick();
    chk("flush_no_write", {31'b0, WriteReg}, 32'd0);
    idle(); repeat (2) tick();

    // HLT followed by a write to r2
    instr(1'b1, 4'd1, 2'b00, 16'h7777, 1'b1); tick();
    instr(1'b1, 4'd2, 2'b00, 16'h2222, 1'b0); tick();
    idle(); repeat (4) tick();
    chk("halt_sticky", {31'b0, wb_halted}, 32'd1);

    // reset with a write in flight
    instr(1'b1, 4'd9, 2'b00, 16'h9999, 1'b0);
    do_reset();
    instr(1'b1, 4'd9, 2'b00, 16'h9999, 1'b0); tick();
    do_reset();

    // randomized traffic
    halt_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      tick();
      if (m_halted) halt_cycles++;
      if ((halt_cycles > 6 && ($urandom % 4) == 0) || ($urandom % 300) == 0) begin
        rand_inputs();
        do_reset();
        halt_cycles = 0;
      end
    end
    idle();
    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
